// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared types and constants for the FFT frame sequencer.
//   seq_state_t   : sequencer FSM states
//   FFT_N         : transform length (bins per magnitude frame)
//   BIN_LAST_KEPT : last magnitude bin the peak search consumes; its beat
//                   launches fft_sampler
//   cnt_width()   : counter width for a modulus, never less than 1 bit
package fft_pkg;

  typedef enum logic [2:0] {
    FILL,
    ARMED,
    SEND,
    MAG,
    SEARCH
  } seq_state_t;

  localparam int FFT_N = 4096;
  localparam logic [9:0] BIN_LAST_KEPT = 10'd1023;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_tick_gen.sv
// fft_tick_gen
//   Pass-rate divider. Counts clk_104mhz cycles from 0 to TICK_COUNT-1 and
//   raises tick for the single cycle the count sits at TICK_COUNT-1, then
//   wraps to 0.
// Ports
//   clk_104mhz  in   system clock
//   rst_n       in   async active-low reset, divider returns to 0
//   tick        out  1-cycle pass request
module fft_tick_gen
  import fft_pkg::*;
#(
  parameter int TICK_COUNT = 1_733_333
) (
  input  logic clk_104mhz,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = cnt_width(TICK_COUNT);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_W'(TICK_COUNT - 1));

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Runs one FFT analysis pass per rate tick: frame send, magnitude capture,
//   peak search, result. No pass starts until the frame buffer has been
//   filled once, and only one pass is ever in flight. Ticks arriving during
//   a pass are dropped and counted. Passes end early on a core tlast
//   misalignment or when they run longer than TIMEOUT_CYCLES.
// Ports
//   clk_104mhz, rst_n          clock, async active-low reset
//   enable                     permit new passes (in-flight pass completes)
//   clear_err                  pulse, clears error flags and overrun count
//   frame_wr                   one pulse per sample written to frame BRAM
//   fft_start                  1-cycle start to bram_to_fft
//   frame_tvalid/tready/tlast  AXIS monitor, bram_to_fft -> fft core
//   last_missing               fft core tlast-missing event
//   mag_tvalid/tlast/tuser     magnitude stream, tuser = bin index
//   sampler_start              1-cycle start to fft_sampler
//   sampler_done               fft_sampler done pulse
//   largest_bucket             fft_sampler result
//   peak_index, peak_valid     result of last good pass, 1-cycle update pulse
//   busy                       pass in flight (SEND/MAG/SEARCH)
//   err_missing, err_timeout   sticky abort causes
//   overrun_count              saturating count of dropped ticks
//
// state  | meaning
// FILL   | waiting for MIN_FILL frame writes after reset, ticks ignored
// ARMED  | idle, next tick with enable starts a pass
// SEND   | frame streaming into the core, waiting for the tlast handshake
// MAG    | magnitude bins arriving, waiting for bin BIN_LAST_KEPT
// SEARCH | sampler running, waiting for sampler_done and mag tlast
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int TICK_COUNT     = 1_733_333,
  parameter int MIN_FILL       = 4096,
  parameter int TIMEOUT_CYCLES = 1_048_576,
  parameter int OVR_W          = 8
) (
  input  logic              clk_104mhz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear_err,
  input  logic              frame_wr,
  output logic              fft_start,
  input  logic              frame_tvalid,
  input  logic              frame_tready,
  input  logic              frame_tlast,
  input  logic              last_missing,
  input  logic              mag_tvalid,
  input  logic              mag_tlast,
  input  logic [11:0]       mag_tuser,
  output logic              sampler_start,
  input  logic              sampler_done,
  input  logic [10:0]       largest_bucket,
  output logic [10:0]       peak_index,
  output logic              peak_valid,
  output logic              busy,
  output logic              err_missing,
  output logic              err_timeout,
  output logic [OVR_W-1:0]  overrun_count
);

  localparam int FILL_W = cnt_width(MIN_FILL + 1);
  localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);

  logic tick;

  fft_tick_gen #(
    .TICK_COUNT(TICK_COUNT)
  ) u_tick_gen (
    .clk_104mhz(clk_104mhz),
    .rst_n     (rst_n),
    .tick      (tick)
  );

  seq_state_t        state;
  logic [FILL_W-1:0] fill_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              tl_seen;
  logic              done_seen;

  logic in_pass;
  logic frame_last_hs;
  logic mag_last_beat;
  logic bin_last_beat;
  logic to_hit;
  logic miss_hit;
  logic search_done;

  assign in_pass       = state inside {SEND, MAG, SEARCH};
  assign frame_last_hs = frame_tvalid & frame_tready & frame_tlast;
  assign mag_last_beat = mag_tvalid & mag_tlast;
  assign bin_last_beat = mag_tvalid & (mag_tuser == {2'b00, BIN_LAST_KEPT});
  assign to_hit        = in_pass & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign miss_hit      = in_pass & last_missing;
  // Sampler result and mag tlast may arrive in either order, or together;
  // include this cycle's events so completion costs no extra cycle.
  assign search_done   = (done_seen | sampler_done) & (tl_seen | mag_last_beat);

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      fill_cnt      <= '0;
      to_cnt        <= '0;
      tl_seen       <= 1'b0;
      done_seen     <= 1'b0;
      fft_start     <= 1'b0;
      sampler_start <= 1'b0;
      peak_index    <= '0;
      peak_valid    <= 1'b0;
      busy          <= 1'b0;
      err_missing   <= 1'b0;
      err_timeout   <= 1'b0;
      overrun_count <= '0;
    end else begin
      fft_start     <= 1'b0;
      sampler_start <= 1'b0;
      peak_valid    <= 1'b0;

      // A new error in the same cycle as clear_err leaves the flag set.
      if (clear_err) begin
        err_missing <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (miss_hit) err_missing <= 1'b1;
      if (to_hit)   err_timeout <= 1'b1;

      // Includes the completing/aborting cycle: state is still a pass state.
      if (tick && in_pass) begin
        if (clear_err) begin
          overrun_count <= OVR_W'(1);
        end else if (!(&overrun_count)) begin
          overrun_count <= overrun_count + 1'b1;
        end
      end else if (clear_err) begin
        overrun_count <= '0;
      end

      if (in_pass) to_cnt <= to_cnt + 1'b1;

      case (state)
        FILL: begin
          if (frame_wr) begin
            if (fill_cnt == FILL_W'(MIN_FILL - 1)) begin
              fill_cnt <= FILL_W'(MIN_FILL);
              state    <= ARMED;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ARMED: begin
          if (tick && enable) begin
            fft_start <= 1'b1;
            to_cnt    <= '0;
            tl_seen   <= 1'b0;
            done_seen <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (frame_last_hs) state <= MAG;
        end
        MAG: begin
          if (mag_last_beat) tl_seen <= 1'b1;
          if (bin_last_beat) begin
            sampler_start <= 1'b1;
            state         <= SEARCH;
          end
        end
        SEARCH: begin
          if (mag_last_beat) tl_seen <= 1'b1;
          if (sampler_done)  done_seen <= 1'b1;
          if (search_done) begin
            peak_index <= largest_bucket;
            peak_valid <= 1'b1;
            tl_seen    <= 1'b0;
            done_seen  <= 1'b0;
            busy       <= 1'b0;
            state      <= ARMED;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= FILL;
        end
      endcase

      // Abort overrides whatever the pass states decided this cycle.
      if (miss_hit || to_hit) begin
        sampler_start <= 1'b0;
        peak_valid    <= 1'b0;
        tl_seen       <= 1'b0;
        done_seen     <= 1'b0;
        busy          <= 1'b0;
        state         <= ARMED;
      end
    end
  end

endmodule
